// File: rtl/pool_pkg.sv
// pool_pkg: constants and types shared by the maxpool result reader.
//
// DATA_W   width of a pooled sample (signed)
// ADDR_W   result RAM address width
// N_ROWS   pooled rows; N_COLS pooled columns; DEPTH = N_ROWS * N_COLS
// ROW_W    width of a row coordinate; COL_W width of a column coordinate
// RAM_LAT  read latency of the result RAM (the reader is built for 1)
package pool_pkg;

    localparam int DATA_W  = 21;
    localparam int ADDR_W  = 13;
    localparam int N_ROWS  = 82;
    localparam int N_COLS  = 62;
    localparam int DEPTH   = N_ROWS * N_COLS;
    localparam int ROW_W   = 7;
    localparam int COL_W   = 6;
    localparam int RAM_LAT = 1;

    localparam logic [ADDR_W-1:0]        LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [COL_W-1:0]         LAST_COL  = COL_W'(N_COLS - 1);
    localparam logic signed [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DRAIN,
        ST_REPORT
    } state_e;

    // One buffered sample: its value, linear index and end-of-frame flag.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] idx;
        logic              last;
    } sample_t;

endpackage

// File: rtl/rd_fifo2.sv
// rd_fifo2: two-entry FIFO holding samples returned by the result RAM.
//
// clk        rising-edge clock
// reset      synchronous, active-low; empties the FIFO and zeroes its storage
// flush      empties the FIFO (storage contents are left as they are)
// push       write push_data/push_idx/push_last
// pop        drop the head entry
// full       two entries held
// empty      no entry held
// head_*     fields of the oldest entry
module rd_fifo2
    import pool_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_idx,
    input  logic              push_last,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_idx,
    output logic              head_last
);

    sample_t    entry_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && ((count_q != 2'd2) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the storage is reset as well, because the head fields are
            // visible outputs that must read zero straight after reset.
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                entry_q[wr_ptr_q] <= '{data: push_data, idx: push_idx, last: push_last};
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign head_data = entry_q[rd_ptr_q].data;
    assign head_idx  = entry_q[rd_ptr_q].idx;
    assign head_last = entry_q[rd_ptr_q].last;

endmodule

// File: rtl/pool_result_reader.sv
// pool_result_reader: sweeps the maxpool result RAM in row-major order once the
// processing top reports done, streams every sample out on valid/ready and
// tracks the signed maximum with its row/column (the template-match position).
//
// clk, reset            clock; synchronous active-low reset
// start, done_in        sweep request; results valid while done_in is high
// rd_en, rd_addr        result RAM read port; rd_data returns one cycle later
// out_valid/out_ready   stream handshake; out_data, out_index, out_last payload
// busy                  sweep in progress
// best_val/row/col/idx  running signed maximum and its location
// result_valid          best_* are final; held until the next start or reset
module pool_result_reader
    import pool_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              done_in,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic [DATA_W-1:0] best_val,
    output logic [ROW_W-1:0]  best_row,
    output logic [COL_W-1:0]  best_col,
    output logic [ADDR_W-1:0] best_idx,
    output logic              result_valid
);

    state_e                   state_q;
    logic [ADDR_W-1:0]        issue_q;
    logic                     cap_q;      // read issued last cycle; rd_data is valid now
    logic [ADDR_W-1:0]        cap_idx_q;
    logic                     busy_q;
    logic                     result_valid_q;
    logic signed [DATA_W-1:0] best_val_q;
    logic [ADDR_W-1:0]        best_idx_q;
    logic [ROW_W-1:0]         best_row_q;
    logic [COL_W-1:0]         best_col_q;
    logic [ROW_W-1:0]         cur_row_q;  // location of the sample at the stream head
    logic [COL_W-1:0]         cur_col_q;

    logic       fifo_full;
    logic       fifo_empty;
    logic [1:0] fifo_occ;
    logic [2:0] occ_after;
    logic       fifo_pop;
    logic       abort;
    logic       rd_en_d;
    logic       new_max;

    rd_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (cap_q),
        .push_data (rd_data),
        .push_idx  (cap_idx_q),
        .push_last (cap_idx_q == LAST_ADDR),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (out_data),
        .head_idx  (out_index),
        .head_last (out_last)
    );

    assign fifo_occ = {fifo_full, !fifo_full && !fifo_empty};

    // NOTE: every signal driven here gets a value on every path, so no latch
    // can be inferred.
    always_comb begin
        fifo_pop  = !fifo_empty && out_ready;
        abort     = ((state_q == ST_SWEEP) || (state_q == ST_DRAIN)) && !done_in;
        // Samples still owed to the FIFO after this edge: what it keeps plus
        // the read whose data is on rd_data now.
        occ_after = {1'b0, fifo_occ} + {2'b00, cap_q} - {2'b00, fifo_pop};
        // The enable is decided in the issuing cycle, using this cycle's pop, so
        // a two-entry FIFO is enough to stream one sample per cycle.
        rd_en_d   = (state_q == ST_SWEEP) && done_in && (occ_after < 3'd2);
        new_max   = fifo_pop && ($signed(out_data) > best_val_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            issue_q        <= '0;
            cap_q          <= 1'b0;
            cap_idx_q      <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            best_val_q     <= '0;
            best_idx_q     <= '0;
            best_row_q     <= '0;
            best_col_q     <= '0;
            cur_row_q      <= '0;
            cur_col_q      <= '0;
        end else begin
            cap_q     <= rd_en_d;
            cap_idx_q <= issue_q;

            // A sample accepted on an aborting edge still counts toward the maximum.
            if (fifo_pop) begin
                if (new_max) begin
                    best_val_q <= $signed(out_data);
                    best_idx_q <= out_index;
                    best_row_q <= cur_row_q;
                    best_col_q <= cur_col_q;
                end
                if (cur_col_q == LAST_COL) begin
                    cur_col_q <= '0;
                    cur_row_q <= cur_row_q + 1'b1;
                end else begin
                    cur_col_q <= cur_col_q + 1'b1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start && done_in) begin
                        state_q        <= ST_SWEEP;
                        busy_q         <= 1'b1;
                        result_valid_q <= 1'b0;
                        issue_q        <= '0;
                        best_val_q     <= MOST_NEG;
                        best_idx_q     <= '0;
                        best_row_q     <= '0;
                        best_col_q     <= '0;
                        cur_row_q      <= '0;
                        cur_col_q      <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (rd_en_d) begin
                        // The counter parks on the last address instead of wrapping.
                        if (issue_q == LAST_ADDR) begin
                            state_q <= ST_DRAIN;
                        end else begin
                            issue_q <= issue_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fifo_pop && out_last) begin
                        state_q        <= ST_REPORT;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                    end
                end
                ST_REPORT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_en        = rd_en_d;
    assign rd_addr      = issue_q;
    assign out_valid    = !fifo_empty;
    assign busy         = busy_q;
    assign best_val     = best_val_q;
    assign best_idx     = best_idx_q;
    assign best_row     = best_row_q;
    assign best_col     = best_col_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_pool_result_reader.sv
// tb_pool_result_reader: drives full and partial sweeps over a behavioural
// result RAM and compares the stream and the reported maximum with values
// computed from the RAM contents.
module tb_pool_result_reader;
    import pool_pkg::*;

    localparam int BUDGET = 40000;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              done_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic [DATA_W-1:0] best_val;
    logic [ROW_W-1:0]  best_row;
    logic [COL_W-1:0]  best_col;
    logic [ADDR_W-1:0] best_idx;
    logic              result_valid;

    int tests  = 0;
    int failed = 0;

    logic [DATA_W-1:0] mem [DEPTH];

    pool_result_reader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .done_in      (done_in),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .best_val     (best_val),
        .best_row     (best_row),
        .best_col     (best_col),
        .best_idx     (best_idx),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    // Result RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int kind);
        for (int i = 0; i < DEPTH; i++) begin
            case (kind)
                0:       mem[i] = DATA_W'(i);
                1:       mem[i] = (i == 130 || i == 4000) ? DATA_W'(12) : DATA_W'(-7);
                2:       mem[i] = (i == 0)  ? DATA_W'(-1048576) :
                                  (i == 63) ? DATA_W'(-5) : DATA_W'(-1000 - (i % 1000));
                default: mem[i] = DATA_W'($urandom);
            endcase
        end
    endtask

    // Maximum over the first n samples; the earliest one wins a tie.
    task automatic model_best(input int n, output logic [DATA_W-1:0] bv, output int bi);
        bv = '0;
        bv[DATA_W-1] = 1'b1;
        bi = 0;
        for (int i = 0; i < n; i++) begin
            if ($signed(mem[i]) > $signed(bv)) begin
                bv = mem[i];
                bi = i;
            end
        end
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, " rd_en"},        rd_en,        0);
        check({name, " rd_addr"},      rd_addr,      0);
        check({name, " out_valid"},    out_valid,    0);
        check({name, " out_payload"},  {out_data, out_index, out_last}, 0);
        check({name, " busy"},         busy,         0);
        check({name, " best"},         {best_val, best_row, best_col, best_idx}, 0);
        check({name, " result_valid"}, result_valid, 0);
    endtask

    // Starts a sweep and follows it until stop_after samples are accepted.
    // Returns at the falling edge just after the edge that took the last one.
    task automatic run_sweep(input string name, input int ready_pct, input int stop_after);
        int   issued = 0;
        int   popped = 0;
        int   cyc = 0;
        int   first_pop = -1;
        int   last_pop = -1;
        logic pop_now;
        logic prev_stall = 1'b0;
        logic [DATA_W+ADDR_W:0] prev_payload = '0;
        logic [DATA_W-1:0] neg;
        neg = '0;
        neg[DATA_W-1] = 1'b1;
        @(negedge clk);
        start = 1'b1;
        done_in = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (popped < stop_after && cyc < BUDGET) begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
            #1;
            if (cyc == 0) begin
                check({name, " busy_at_start"}, busy, 1);
                check({name, " rv_cleared"}, result_valid, 0);
                check({name, " best_init"}, best_val, neg);
            end
            pop_now = out_valid && out_ready;
            if (prev_stall)
                check({name, " stall_hold"}, {out_valid, out_data, out_index, out_last},
                      {1'b1, prev_payload});
            if (rd_en) begin
                check({name, " rd_addr"}, rd_addr, issued);
                check({name, " credit"}, (issued - popped - int'(pop_now)) < 2, 1);
                issued++;
            end
            if (pop_now) begin
                check({name, " sample"}, {out_index, out_data, out_last},
                      {ADDR_W'(popped), mem[popped], popped == DEPTH - 1});
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                popped++;
            end
            prev_stall   = out_valid && !out_ready;
            prev_payload = {out_data, out_index, out_last};
            cyc++;
            @(negedge clk);
        end
        if (popped < stop_after) check({name, " timeout"}, popped, stop_after);
        if (ready_pct == 100) check({name, " throughput"}, last_pop - first_pop + 1, stop_after);
        if (stop_after == DEPTH) check({name, " issued"}, issued, DEPTH);
    endtask

    task automatic check_report(input string name, input logic [DATA_W-1:0] ev,
                                input int ei, input int er, input int ec);
        #1;
        check({name, " report_rv"},   result_valid, 1);
        check({name, " report_busy"}, busy, 0);
        check({name, " best_val"},    best_val, ev);
        check({name, " best_idx"},    best_idx, ei);
        check({name, " best_row"},    best_row, er);
        check({name, " best_col"},    best_col, ec);
        check({name, " fifo_empty"},  out_valid, 0);
        @(negedge clk);
        #1;
        check({name, " idle_rv_held"}, {result_valid, busy, rd_en}, 3'b100);
    endtask

    typedef struct {
        string             name;
        int                kind;
        int                ready_pct;
        bit                use_model;
        logic [DATA_W-1:0] exp_val;
        int                exp_idx;
        int                exp_row;
        int                exp_col;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic [DATA_W-1:0] ev;
        int ei;

        vecs[0] = '{"ramp",     0, 100, 1'b0, DATA_W'(5083), 5083, 81, 61};
        vecs[1] = '{"twin12",   1, 100, 1'b0, DATA_W'(12),    130,  2,  6};
        vecs[2] = '{"negative", 2, 100, 1'b0, DATA_W'(-5),     63,  1,  1};
        vecs[3] = '{"rand30",   3,  30, 1'b1, '0, 0, 0, 0};
        vecs[4] = '{"rand70",   3,  70, 1'b1, '0, 0, 0, 0};

        reset = 1'b0;
        start = 1'b0;
        done_in = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        // start without done_in is ignored
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            #1;
            check("nodone_idle", {busy, rd_en, out_valid, result_valid}, 4'b0000);
            @(negedge clk);
        end

        for (int v = 0; v < 5; v++) begin
            fill_mem(vecs[v].kind);
            if (vecs[v].use_model) begin
                model_best(DEPTH, ev, ei);
                vecs[v].exp_val = ev;
                vecs[v].exp_idx = ei;
                vecs[v].exp_row = ei / N_COLS;
                vecs[v].exp_col = ei % N_COLS;
            end
            run_sweep(vecs[v].name, vecs[v].ready_pct, DEPTH);
            check_report(vecs[v].name, vecs[v].exp_val, vecs[v].exp_idx,
                         vecs[v].exp_row, vecs[v].exp_col);
        end

        // start without done_in after a sweep leaves the result in place
        @(negedge clk);
        done_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("nodone_hold", {busy, rd_en, result_valid}, 3'b001);

        // reset in the middle of a sweep, then a complete sweep
        fill_mem(3);
        run_sweep("rst_mid", 100, 1000);
        reset = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_zero_outputs("rst_mid");
        reset = 1'b1;
        model_best(DEPTH, ev, ei);
        run_sweep("after_rst", 100, DEPTH);
        check_report("after_rst", ev, ei, ei / N_COLS, ei % N_COLS);

        // done_in falls mid-sweep: flush, no result, partial maximum kept
        fill_mem(3);
        run_sweep("abort", 60, 700);
        done_in = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        model_best(700, ev, ei);
        check("abort_state", {busy, rd_en, out_valid, result_valid}, 4'b0000);
        check("abort_best", {best_val, best_idx, best_row, best_col},
              {ev, ADDR_W'(ei), ROW_W'(ei / N_COLS), COL_W'(ei % N_COLS)});
        @(negedge clk);
        #1;
        check("abort_stays_idle", {busy, rd_en, out_valid}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pool_result_reader.md
Name: pool_result_reader

Overview:
- Read-side master for the maxpool result RAM once the convolution/maxpool top asserts done.
- Drives that RAM's external read port (enable/addr; data one cycle later), sweeps every pooled sample in row-major order, and streams each sample out on a valid/ready interface.
- Tracks the signed maximum and its row/column; that location is the template-match position reported to downstream classification logic.

Parameters:
- DATA_W, 21, width of a pooled sample (signed).
- ADDR_W, 13, result RAM address width.
- N_ROWS, 82, pooled rows.
- N_COLS, 62, pooled columns; DEPTH = N_ROWS*N_COLS = 5084, must be ≤ 2^ADDR_W.
- RAM_LAT, 1, read latency of the result RAM in cycles; only 1 is supported.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous, active-low.
- start, in, 1, one-cycle request to begin a sweep.
- done_in, in, 1, done from the processing top; results are valid while high.
- rd_en, out, 1, result RAM enable, driving the top's enable.
- rd_addr, out, ADDR_W, result RAM address, driving the top's addr.
- rd_data, in, DATA_W, result RAM data (signed), valid RAM_LAT cycles after rd_en.
- out_valid, out, 1, stream sample valid.
- out_ready, in, 1, stream sample accepted.
- out_data, out, DATA_W, sample value.
- out_index, out, ADDR_W, linear index of the sample.
- out_last, out, 1, high with index DEPTH-1.
- busy, out, 1, sweep in progress.
- best_val, out, DATA_W, signed maximum.
- best_row, out, 7, row of the maximum.
- best_col, out, 6, column of the maximum.
- best_idx, out, ADDR_W, linear index of the maximum.
- result_valid, out, 1, best_* are final; held until the next start or reset.

Behaviour:
- Reset (reset==0 at clk edge): state IDLE. All outputs 0: rd_en, rd_addr, out_valid, out_data, out_index, out_last, busy, best_*, result_valid. FIFO emptied; in-flight read discarded.
- States: IDLE, SWEEP, DRAIN, REPORT.
- IDLE -> SWEEP on start && done_in.
  - Clears result_valid.
  - Loads best_val = most negative DATA_W value; best_idx/row/col = 0.
  - Issue counter = 0; busy = 1.
  - start without done_in is ignored, staying in IDLE.
- SWEEP: issue a read (rd_en=1, rd_addr=issue counter) only when FIFO occupancy + in-flight reads < 2.
  - rd_en=0 otherwise; rd_addr holds its value.
  - On the cycle the read of DEPTH-1 is issued -> DRAIN.
- Capture: the rd_data that returns RAM_LAT cycles after an issued read is pushed into a 2-entry FIFO with its index.
  - No data is ever dropped.
  - With out_ready held high, throughput is one sample per cycle.
- Stream:
  - out_valid = FIFO not empty; out_data/out_index/out_last come from the FIFO head.
  - Pop on out_valid && out_ready.
  - While out_valid && !out_ready, all stream outputs hold stable.
- Max tracking happens on each pop.
  - Signed strict compare: if out_data > best_val, update best_val, best_idx and the row/col counters.
  - On ties the first (lowest index) wins.
  - Row/col counters advance per pop: col wraps at N_COLS-1 to 0 and increments row.
- DRAIN -> REPORT when the pop with out_last completes, including the update from that sample.
- REPORT: one cycle. result_valid=1, busy=0 -> IDLE. result_valid stays 1 in IDLE.
- done_in falling during SWEEP/DRAIN: abort.
  - Go to IDLE, flush the FIFO, busy=0, result_valid stays 0, best_* hold partial values.
  - Samples already presented are not retracted mid-handshake; the flush happens on the next edge.
- start during SWEEP/DRAIN/REPORT: ignored.
- Address arithmetic: the issue counter never exceeds DEPTH-1; no wrap-around. out_index equals the issued address for that sample.
- Simultaneous push and pop with FIFO full: legal; occupancy is unchanged.

Decomposition:
- Shared package pool_pkg:
  - DATA_W, ADDR_W, N_ROWS, N_COLS, DEPTH.
  - State enum.
  - Signed most-negative constant.
- One sub-module, rd_fifo2: a 2-entry FIFO with data+index+last, push/pop/full/empty and synchronous active-low reset.
- The FSM, issue logic, credit count and max tracker stay in pool_result_reader.

Test Plan:
- RAM model holding value = index; out_ready=1; start with done_in=1 -> 5084 samples in order, one per cycle after fill. out_last only at index 5083. best_val=5083, best_idx=5083, best_row=81, best_col=61, result_valid=1.
- All entries -7 except 12 at indices 130 and 4000 -> best_val=12, best_idx=130, row=2, col=6 (first wins).
- All entries negative (-1048576 at 0, -5 at 63) -> best_val=-5, best_idx=63, row=1, col=1; signed compare confirmed.
- out_ready random 30% duty -> no sample lost or duplicated; indices contiguous; outputs stable while stalled; rd_en never issues with FIFO+in-flight ≥ 2.
- start with done_in=0 -> stays IDLE, rd_en=0, busy=0.
- reset low at sample 1000 -> next cycle all outputs 0, state IDLE. A new start then completes a full sweep correctly.
